// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and axis-step helper for sprite_mover.
package sprite_pkg;

    localparam int X_BITS      = 8;
    localparam int Y_BITS      = 7;
    localparam int COLOUR_BITS = 3;
    localparam int AXIS_BITS   = X_BITS + 1;

    localparam int DIR_LEFT  = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_DOWN  = 3;

    typedef enum logic [2:0] {
        INIT,
        WAIT,
        ERASE,
        MOVE,
        DRAW
    } state_t;

    // One axis, one frame: clamp or wrap at the bounds; opposing requests cancel.
    function automatic logic [AXIS_BITS-1:0] step_axis(
        input logic [AXIS_BITS-1:0] pos,
        input logic                 dec,
        input logic                 inc,
        input logic [AXIS_BITS-1:0] lo,
        input logic [AXIS_BITS-1:0] hi,
        input logic [AXIS_BITS-1:0] sp,
        input logic                 wrap
    );
        logic [AXIS_BITS-1:0] r;
        r = pos;
        if (dec && !inc) begin
            if (pos < lo + sp) r = wrap ? hi : lo;
            else               r = pos - sp;
        end else if (inc && !dec) begin
            if (pos + sp > hi) r = wrap ? lo : hi;
            else               r = pos + sp;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_mover_frame_tick.sv
// Frame pacing: down-counter from FRAME_TICKS-1 with a one-cycle tick at zero.
module frame_tick #(
    parameter int unsigned FRAME_TICKS = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = $clog2(FRAME_TICKS + 1);
    localparam logic [CW-1:0] TOP = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)              count <= TOP;
        else if (count == '0)   count <= TOP;
        else                    count <= count - 1'b1;
    end

    assign tick = (count == '0);

endmodule

// File: rtl/sprite_mover.sv
// Single rectangular sprite: erase/move/draw once per frame into a VGA pixel port.
// Define SPRITE_WRAP_EN to wrap at the bounds instead of clamping.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int SPRITE_W    = 4,
    parameter int SPRITE_H    = 4,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 150,
    parameter int Y_MIN       = 10,
    parameter int Y_MAX       = 110,
    parameter int START_X     = 80,
    parameter int START_Y     = 50,
    parameter int SPEED       = 1,
    parameter logic [COLOUR_BITS-1:0] FG_COLOUR = 3'b010,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR = 3'b000,
    parameter int FRAME_TICKS = 833333
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [3:0]             dir,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic [X_BITS-1:0]      pos_x,
    output logic [Y_BITS-1:0]      pos_y,
    output logic                   frame_done
);

`ifdef SPRITE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    localparam logic [3:0] COL_LAST = 4'(SPRITE_W - 1);
    localparam logic [3:0] ROW_LAST = 4'(SPRITE_H - 1);

    state_t state, next_state;
    logic [3:0] col, row;
    logic pending, tick, last_pix;
    logic scanning, plot_n, use_fg, done_n, do_move;
    logic [AXIS_BITS-1:0] nx, ny;

    frame_tick #(.FRAME_TICKS(FRAME_TICKS)) u_tick (
        .clk   (CLOCK_50),
        .reset (reset),
        .tick  (tick)
    );

    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    assign nx = step_axis({1'b0, pos_x}, dir[DIR_LEFT], dir[DIR_RIGHT],
                          AXIS_BITS'(X_MIN), AXIS_BITS'(X_MAX), AXIS_BITS'(SPEED), WRAP);
    assign ny = step_axis({2'b00, pos_y}, dir[DIR_UP], dir[DIR_DOWN],
                          AXIS_BITS'(Y_MIN), AXIS_BITS'(Y_MAX), AXIS_BITS'(SPEED), WRAP);

    always_comb begin
        next_state = state;
        scanning   = 1'b0;
        plot_n     = 1'b0;
        use_fg     = 1'b1;
        done_n     = 1'b0;
        do_move    = 1'b0;
        case (state)
            INIT: begin
                scanning = 1'b1;
                plot_n   = 1'b1;
                if (last_pix) next_state = WAIT;
            end
            WAIT: begin
                if (pending) next_state = ERASE;
            end
            ERASE: begin
                scanning = 1'b1;
                plot_n   = 1'b1;
                use_fg   = 1'b0;
                if (last_pix) next_state = MOVE;
            end
            MOVE: begin
                do_move    = 1'b1;
                next_state = DRAW;
            end
            DRAW: begin
                scanning = 1'b1;
                plot_n   = 1'b1;
                if (last_pix) begin
                    done_n     = 1'b1;
                    next_state = WAIT;
                end
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= INIT;
        else       state <= next_state;
    end

    // Every tick lands in pending; WAIT consumes it, so missed ticks merge into one frame.
    always_ff @(posedge CLOCK_50) begin
        if (reset)              pending <= 1'b0;
        else if (tick)          pending <= 1'b1;
        else if (state == WAIT) pending <= 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || !scanning) begin
            col <= '0;
            row <= '0;
        end else if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
            col <= col + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pos_x <= X_BITS'(START_X);
            pos_y <= Y_BITS'(START_Y);
        end else if (do_move) begin
            pos_x <= X_BITS'(nx);
            pos_y <= Y_BITS'(ny);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            x          <= pos_x + X_BITS'(col);
            y          <= pos_y + Y_BITS'(row);
            colour     <= plot_n ? (use_fg ? FG_COLOUR : BG_COLOUR) : '0;
            plot       <= plot_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: a 64-tick instance for motion/timing, a 20-tick one for missed ticks.
module tb_sprite_mover;

`ifdef SPRITE_WRAP_EN
    localparam bit WRAP_TB = 1'b1;
`else
    localparam bit WRAP_TB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset_f, sel;
    logic [3:0] dir;
    logic [7:0] x_m, x_f, px_m, px_f, ox, opx;
    logic [6:0] y_m, y_f, py_m, py_f, oy, opy;
    logic [2:0] c_m, c_f, oc;
    logic       pl_m, pl_f, fd_m, fd_f, opl, ofd;

    int checks = 0;
    int fails  = 0;

    sprite_mover #(.FRAME_TICKS(64)) dut (
        .CLOCK_50(clk), .reset(reset), .dir(dir), .x(x_m), .y(y_m), .colour(c_m),
        .plot(pl_m), .pos_x(px_m), .pos_y(py_m), .frame_done(fd_m)
    );

    sprite_mover #(.FRAME_TICKS(20)) dut_fast (
        .CLOCK_50(clk), .reset(reset_f), .dir(dir), .x(x_f), .y(y_f), .colour(c_f),
        .plot(pl_f), .pos_x(px_f), .pos_y(py_f), .frame_done(fd_f)
    );

    always_comb begin
        ox  = sel ? x_f  : x_m;
        oy  = sel ? y_f  : y_m;
        oc  = sel ? c_f  : c_m;
        opl = sel ? pl_f : pl_m;
        ofd = sel ? fd_f : fd_m;
        opx = sel ? px_f : px_m;
        opy = sel ? py_f : py_m;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_plot(output int n);
        n = 0;
        while (opl !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_block(input string tag, input int x0, input int y0,
                               input logic [2:0] c, input bit done_last);
        for (int i = 0; i < 16; i++) begin
            chk({tag, " plot"},   32'(opl), 32'd1);
            chk({tag, " x"},      32'(ox),  32'(x0 + i % 4));
            chk({tag, " y"},      32'(oy),  32'(y0 + i / 4));
            chk({tag, " colour"}, 32'(oc),  32'(c));
            chk({tag, " done"},   32'(ofd), 32'(done_last && i == 15));
            @(negedge clk);
        end
        chk({tag, " plot_off"}, 32'(opl), 32'd0);
        chk({tag, " done_off"}, 32'(ofd), 32'd0);
    endtask

    task automatic do_frame(input string tag, input logic [3:0] d, input int gap,
                            input int ox0, input int oy0, input int nx0, input int ny0);
        int n;
        dir = d;
        wait_plot(n);
        if (gap >= 0) chk({tag, " gap"}, 32'(n), 32'(gap));
        check_block({tag, " erase"}, ox0, oy0, 3'b000, 1'b0);
        wait_plot(n);
        chk({tag, " move_gap"}, 32'(n), 32'd1);
        check_block({tag, " draw"}, nx0, ny0, 3'b010, 1'b1);
        chk({tag, " pos_x"}, 32'(opx), 32'(nx0));
        chk({tag, " pos_y"}, 32'(opy), 32'(ny0));
    endtask

    initial begin
        int n, cx, nxe;
        sel = 1'b0; reset = 1'b1; reset_f = 1'b1; dir = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst plot",   32'(pl_m), 32'd0);
        chk("rst x",      32'(x_m),  32'd0);
        chk("rst y",      32'(y_m),  32'd0);
        chk("rst colour", 32'(c_m),  32'd0);
        chk("rst done",   32'(fd_m), 32'd0);
        chk("rst pos_x",  32'(px_m), 32'd80);
        chk("rst pos_y",  32'(py_m), 32'd50);
        reset = 1'b0;

        wait_plot(n);
        chk("init gap", 32'(n), 32'd1);
        check_block("init", 80, 50, 3'b010, 1'b0);

        // First tick: counter reaches 0 after 63 edges, two more edges to the first erase pixel.
        do_frame("left1", 4'b0001, 49, 80, 50, 79, 50);
        cx = 79;
        while (cx > 10) begin
            do_frame("walk", 4'b0001, 31, cx, 50, cx - 1, 50);
            cx--;
        end
        for (int k = 0; k < 3; k++) begin
            nxe = WRAP_TB ? ((cx == 10) ? 150 : cx - 1) : 10;
            do_frame("edge", 4'b0001, 31, cx, 50, nxe, 50);
            cx = nxe;
        end
        do_frame("lr",   4'b0011, 31, cx,     50, cx,     50);
        do_frame("ud",   4'b1100, 31, cx,     50, cx,     50);
        do_frame("dr",   4'b1010, 31, cx,     50, cx + 1, 51);
        do_frame("ul",   4'b0101, 31, cx + 1, 51, cx,     50);

        dir = 4'b0001;
        wait_plot(n);
        chk("pre_rst gap", 32'(n), 32'd31);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst plot",  32'(pl_m), 32'd0);
        chk("mid_rst pos_x", 32'(px_m), 32'd80);
        chk("mid_rst pos_y", 32'(py_m), 32'd50);
        reset = 1'b0;
        wait_plot(n);
        chk("reinit gap", 32'(n), 32'd1);
        check_block("reinit", 80, 50, 3'b010, 1'b0);

        sel = 1'b1; dir = 4'b0000;
        reset_f = 1'b0;
        wait_plot(n);
        chk("fast init gap", 32'(n), 32'd1);
        check_block("fast init", 80, 50, 3'b010, 1'b0);
        do_frame("fast0", 4'b0000, -1, 80, 50, 80, 50);
        for (int k = 0; k < 3; k++)
            do_frame("fast", 4'b0000, 1, 80, 50, 80, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
